// File: rtl/wide_add_seq_if.sv
// Handshake bundle between operand producer, add/sub sequencer and result
// consumer. The producer/consumer side uses the master modport; the
// sequencer uses the slave modport.
interface wide_add_seq_if #(
    parameter int WIDTH = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/wide_add_seq.sv
// Wide add/subtract sequencer: one CHUNK-bit carry-lookahead adder is reused
// once per chunk, LSB chunk first, with the inter-chunk carry held in a
// register. Results are held until the consumer accepts them.

// N-bit carry-lookahead adder built from 4-bit lookahead groups whose group
// carries are chained. N must be a multiple of 4.
module cla #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    localparam int NG = N / 4;

    // Carries out of bit positions 0..3 of a 4-bit group, fully looked ahead.
    function automatic logic [3:0] la4(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       c0
    );
        logic [3:0] c;
        c[0] = g[0] | (p[0] & c0);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic [N-1:0] g_s;
    logic [N-1:0] p_s;
    logic         gc_s;
    logic [3:0]   cc_s;

    // Generate/propagate per bit, lookahead inside each group, chain group carries.
    always_comb begin
        g_s  = a & b;
        p_s  = a ^ b;
        s    = '0;
        gc_s = ci;
        cc_s = 4'b0000;
        for (int k = 0; k < NG; k++) begin
            cc_s         = la4(g_s[4*k +: 4], p_s[4*k +: 4], gc_s);
            s[4*k +: 4]  = p_s[4*k +: 4] ^ {cc_s[2:0], gc_s};
            gc_s         = cc_s[3];
        end
        co = gc_s;
    end
endmodule

module wide_add_seq #(
    parameter int WIDTH = 128,
    parameter int CHUNK = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    wide_add_seq_if.slave      bus
);
    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [IDXW-1:0]    idx_r;
    logic               carry_r;
    logic [WIDTH-1:0]   opa_r;
    logic [WIDTH-1:0]   opb_r;
    logic               a_msb_r;
    logic               b_msb_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               ovf_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    logic [CHUNK-1:0]   slice_a_s;
    logic [CHUNK-1:0]   slice_b_s;
    logic [CHUNK-1:0]   slice_sum_s;
    logic               slice_co_s;
    logic               last_s;

    // Select the chunk of each captured operand that is being added this cycle.
    always_comb begin
        slice_a_s = opa_r[idx_r*CHUNK +: CHUNK];
        slice_b_s = opb_r[idx_r*CHUNK +: CHUNK];
        last_s    = (idx_r == IDXW'(NCH - 1));
    end

    cla #(.N(CHUNK)) u_cla (
        .a  (slice_a_s),
        .b  (slice_b_s),
        .ci (carry_r),
        .s  (slice_sum_s),
        .co (slice_co_s)
    );

    // Sequencer FSM: capture operands, walk the chunks, hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= '0;
            carry_r     <= 1'b0;
            opa_r       <= '0;
            opb_r       <= '0;
            a_msb_r     <= 1'b0;
            b_msb_r     <= 1'b0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction is A + ~B + 1; the +1 rides in on the carry.
                        opa_r      <= bus.a;
                        opb_r      <= bus.sub ? ~bus.b : bus.b;
                        carry_r    <= bus.sub ? 1'b1 : bus.cin;
                        a_msb_r    <= bus.a[WIDTH-1];
                        b_msb_r    <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
                        idx_r      <= '0;
                        state_r    <= ST_RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sum_r[idx_r*CHUNK +: CHUNK] <= slice_sum_s;
                    carry_r                     <= slice_co_s;
                    if (last_s) begin
                        cout_r      <= slice_co_s;
                        ovf_r       <= (a_msb_r ~^ b_msb_r) & (slice_sum_s[CHUNK-1] ^ a_msb_r);
                        idx_r       <= '0;
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    // A pending in_valid is not looked at here; it is taken from IDLE.
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    idx_r       <= '0;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: doc/wide_add_seq.md
Name: wide_add_seq

Overview:
- Multi-cycle sequencer that performs WIDTH-bit add/subtract by time-sharing one CHUNK-bit CLA instance.
  - The CLA is the team's existing N-parameterised carry-lookahead adder.
  - The sequencer processes one chunk per cycle, LSB chunk first, and registers the carry between chunks.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- Trades throughput for area when operand width exceeds a single-cycle adder budget.

Parameters:
- WIDTH, 128, total operand width. Must be a multiple of CHUNK.
- CHUNK, 32, adder slice width passed to the CLA as N. Must be a multiple of 4 and at least 8.
- NCH (derived, not overridable): WIDTH/CHUNK. Index width is clog2(NCH), minimum 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset. Asynchronous assert, active-low.
- in_valid  in  1  producer has an operation.
- in_ready  out  1  sequencer can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in. Ignored when sub=1.
- sub  in  1  1 = compute A-B, 0 = compute A+B+cin.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, idx=0, carry reg=0, sum=0, cout=0, ovf=0, out_valid=0.
  - in_ready=1 while rst_n=0 and after release.
  - Reset mid-RUN or in DONE aborts the operation. No out_valid is produced for the aborted operation.
- States: IDLE, RUN, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE), driven from a register.
  - busy = (state!=IDLE).
- IDLE: on in_valid & in_ready:
  - capture a into opa and (sub ? ~b : b) into opb;
  - carry reg = sub ? 1 : cin;
  - capture the MSBs of a and of the effective b for overflow;
  - idx=0; go to RUN.
  - sum/cout/ovf keep the previous result until overwritten.
- RUN: each cycle the CLA adds opa[idx*CHUNK +: CHUNK] + opb[same slice] + carry reg.
  - Write the slice result into sum[idx*CHUNK +: CHUNK].
  - carry reg <= CLA cout.
  - If idx==NCH-1:
    - cout <= CLA cout;
    - ovf <= (a_msb ~^ b_eff_msb) & (sum_msb ^ a_msb), computed from the slice result being written;
    - go to DONE; idx <= 0.
  - Else idx <= idx+1.
- DONE: hold sum/cout/ovf and out_valid stable until out_ready=1, then return to IDLE.
  - in_valid is ignored in RUN and DONE (in_ready=0). A new operation can be accepted in the cycle after DONE exits.
- Latency: operation accepted at clock edge T0 → out_valid=1 in the cycle following edge T0+NCH.
- Throughput: at most one operation per NCH+2 cycles with out_ready tied high.
- Width rules:
  - No truncation except the final carry, which goes to cout.
  - sum always holds the full WIDTH-bit modular result.
- Simultaneous in_valid with out_ready in DONE: the result is retired only. No operation is accepted in that cycle.
- Operand inputs a, b, cin, sub may change freely after acceptance. Only the captured copies are used.

Test Plan (WIDTH=128, CHUNK=32, NCH=4):
- Carry ripple across all chunks: a=all ones, b=1, cin=0, sub=0 → sum=0, cout=1, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- Subtract with borrow: a=0, b=1, sub=1 → sum=all ones, cout=0, ovf=0. Then a=5, b=3, sub=1 → sum=2, cout=1.
- Signed overflow: a=0x7FFF…FFFF, b=1, sub=0 → sum=0x8000…0000, ovf=1, cout=0.
- Backpressure: out_ready=0 for 10 cycles after a result, with in_valid=1 throughout.
  - Required: out_valid, sum, cout, ovf stable and in_ready=0 for all 10 cycles.
  - Then out_ready=1 for one cycle → IDLE; the held in_valid operation is accepted next cycle.
- Reset mid-operation: pull rst_n low 2 cycles into RUN.
  - Required: out_valid=0, sum=0, in_ready=1 immediately (asynchronously).
  - After release, a=0, b=0, cin=1 → sum=1, cout=0.
- Back-to-back random: 1000 random a/b/cin/sub with random out_ready gaps → every result matches the reference model for 129-bit add/sub. No lost or duplicated results.
